// File: rtl/stage_writeback_pkg.sv
// Shared types for the writeback stage: load-type encodings and the MEM/WB
// pipeline register layout.
package stage_writeback_pkg;

  localparam int unsigned XlenW   = 32;
  localparam int unsigned RegIdxW = 5;
  localparam int unsigned MemopW  = 3;

  // Load type carried down the pipe; codes 5-7 are not enumerated and decode as LW.
  typedef enum logic [MemopW-1:0] {
    MemopLw  = 3'd0,
    MemopLh  = 3'd1,
    MemopLhu = 3'd2,
    MemopLb  = 3'd3,
    MemopLbu = 3'd4
  } memop_e;

  // MEM/WB pipeline register contents.
  typedef struct packed {
    logic               valid;
    logic               regwrite;
    logic               memtoreg;
    logic [MemopW-1:0]  memop;
    logic [XlenW-1:0]   aluout;
    logic [XlenW-1:0]   readdata;
    logic [RegIdxW-1:0] writereg;
  } mem_wb_t;

  // Widen a byte to a full word, sign- or zero-extending.
  function automatic logic [XlenW-1:0] extend_byte(logic [7:0] b, logic sext);
    return {{(XlenW-8){sext & b[7]}}, b};
  endfunction

  // Widen a halfword to a full word, sign- or zero-extending.
  function automatic logic [XlenW-1:0] extend_half(logic [15:0] h, logic sext);
    return {{(XlenW-16){sext & h[15]}}, h};
  endfunction

endpackage

// File: rtl/stage_writeback_load_align.sv
// load_align: pulls the addressed byte/halfword out of an aligned memory word,
// extends it to 32 bits and flags accesses that straddle their natural alignment.
module load_align
  import stage_writeback_pkg::*;
(
  input  logic [MemopW-1:0] memop_i,
  input  logic [1:0]        offset_i,
  input  logic [XlenW-1:0]  rdata_i,
  output logic [XlenW-1:0]  data_o,
  output logic              misalign_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Little-endian lane selection from the byte offset.
  always_comb begin
    byte_sel = rdata_i[7:0];
    case (offset_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  // Extension per load type and alignment check; unknown codes behave as LW.
  always_comb begin
    data_o     = rdata_i;
    misalign_o = 1'b0;
    case (memop_i)
      MemopLb: begin
        data_o = extend_byte(byte_sel, 1'b1);
      end
      MemopLbu: begin
        data_o = extend_byte(byte_sel, 1'b0);
      end
      MemopLh: begin
        data_o     = extend_half(half_sel, 1'b1);
        misalign_o = offset_i[0];
      end
      MemopLhu: begin
        data_o     = extend_half(half_sel, 1'b0);
        misalign_o = offset_i[0];
      end
      default: begin
        data_o     = rdata_i;
        misalign_o = |offset_i;
      end
    endcase
  end

endmodule

// File: rtl/stage_writeback.sv
// stage_writeback: MEM/WB pipeline register plus load extraction and register
// file write control. Define WB_RETIRE_CNT_EN to build the retired-instruction
// counter and its retired_WB output.
module stage_writeback
  import stage_writeback_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_M,
  input  logic                REGWRITE_M,
  input  logic                MEMTOREG_M,
  input  logic [MemopW-1:0]   memop_M,
  input  logic [XlenW-1:0]    aluout_M,
  input  logic [XlenW-1:0]    readdata_M,
  input  logic [RegIdxW-1:0]  writereg_M,
  input  logic                stall_W,
  input  logic                flush_W,
  output logic                REGWRITE_WB,
  output logic [XlenW-1:0]    result_WB,
  output logic [RegIdxW-1:0]  writereg_WB,
  output logic                misalign_WB
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0]    retired_WB
`endif
);

  if (CNT_W == 0) begin : gen_bad_cnt_w
    $error("stage_writeback: CNT_W must be nonzero");
  end

  mem_wb_t          wb_q, wb_d;
  logic             held_q, held_d;
  logic [XlenW-1:0] load_data;
  logic             align_mis;
  logic             misaligned;

  // Next MEM/WB contents: flush beats stall beats capture.
  always_comb begin
    wb_d   = wb_q;
    held_d = 1'b0;
    if (flush_W) begin
      wb_d.valid    = 1'b0;
      wb_d.regwrite = 1'b0;
      wb_d.memtoreg = MEMTOREG_M;
      wb_d.memop    = memop_M;
      wb_d.aluout   = aluout_M;
      wb_d.readdata = readdata_M;
      wb_d.writereg = writereg_M;
    end else if (stall_W) begin
      // Contents hold; remember the instruction has already had its write cycle.
      held_d = 1'b1;
    end else begin
      wb_d.valid    = valid_M;
      wb_d.regwrite = REGWRITE_M;
      wb_d.memtoreg = MEMTOREG_M;
      wb_d.memop    = memop_M;
      wb_d.aluout   = aluout_M;
      wb_d.readdata = readdata_M;
      wb_d.writereg = writereg_M;
    end
  end

  // MEM/WB register and stall-held flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_q   <= '0;
      held_q <= 1'b0;
    end else begin
      wb_q   <= wb_d;
      held_q <= held_d;
    end
  end

  load_align u_load_align (
    .memop_i    (wb_q.memop),
    .offset_i   (wb_q.aluout[1:0]),
    .rdata_i    (wb_q.readdata),
    .data_o     (load_data),
    .misalign_o (align_mis)
  );

  // Register file write port; a held instruction writes only in its first cycle.
  always_comb begin
    misaligned  = wb_q.valid & wb_q.memtoreg & align_mis;
    misalign_WB = misaligned;
    result_WB   = wb_q.memtoreg ? load_data : wb_q.aluout;
    writereg_WB = wb_q.writereg;
    REGWRITE_WB = wb_q.valid & wb_q.regwrite & ~misaligned & (|wb_q.writereg) & ~held_q;
  end

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire_evt;

  // An instruction retires when it leaves WB: any edge that does not hold it.
  always_comb begin
    retire_evt = wb_q.valid & (flush_W | ~stall_W);
    retired_d  = retire_evt ? retired_q + 1'b1 : retired_q;
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign retired_WB = retired_q;
`endif

endmodule

// File: tb/tb_stage_writeback.sv
// Directed bench for stage_writeback with a transaction-level reference model.
// Build with WB_RETIRE_CNT_EN defined to also exercise the 4-bit retire counter.
module tb_stage_writeback;

`ifdef WB_RETIRE_CNT_EN
  localparam int unsigned CntW = 4;
`else
  localparam int unsigned CntW = 32;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_M, REGWRITE_M, MEMTOREG_M;
  logic [2:0]  memop_M;
  logic [31:0] aluout_M, readdata_M;
  logic [4:0]  writereg_M;
  logic        stall_W, flush_W;
  logic        REGWRITE_WB;
  logic [31:0] result_WB;
  logic [4:0]  writereg_WB;
  logic        misalign_WB;
`ifdef WB_RETIRE_CNT_EN
  logic [CntW-1:0] retired_WB;
`endif

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  stage_writeback #(.CNT_W(CntW)) dut (
    .clk         (clk),
    .reset       (reset),
    .valid_M     (valid_M),
    .REGWRITE_M  (REGWRITE_M),
    .MEMTOREG_M  (MEMTOREG_M),
    .memop_M     (memop_M),
    .aluout_M    (aluout_M),
    .readdata_M  (readdata_M),
    .writereg_M  (writereg_M),
    .stall_W     (stall_W),
    .flush_W     (flush_W),
    .REGWRITE_WB (REGWRITE_WB),
    .result_WB   (result_WB),
    .writereg_WB (writereg_WB),
    .misalign_WB (misalign_WB)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retired_WB  (retired_WB)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // The instruction sitting in WB, whether it has used its write cycle, and
  // how many instructions have left WB.
  bit          m_valid, m_rw, m_mtr, m_wrote;
  logic [2:0]  m_op;
  logic [31:0] m_addr, m_data;
  logic [4:0]  m_wr;
  int unsigned m_retired;

  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr,
                                           input logic [31:0] data);
    logic [31:0] b, h;
    b = (data >> (8 * (addr % 4))) & 32'hFF;
    h = (data >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
    case (op)
      3'd3:    return (b >= 32'h80) ? b - 32'h100 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'h8000) ? h - 32'h10000 : h;
      3'd2:    return h;
      default: return data;
    endcase
  endfunction

  function automatic bit ref_misalign(input logic [2:0] op, input logic [31:0] addr);
    if (op == 3'd1 || op == 3'd2) return (addr % 2) != 0;
    if (op == 3'd3 || op == 3'd4) return 1'b0;
    return (addr % 4) != 0;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_valid = 0; m_rw = 0; m_mtr = 0; m_wrote = 0;
      m_op = '0; m_addr = '0; m_data = '0; m_wr = '0; m_retired = 0;
    end else if (flush_W || !stall_W) begin
      if (m_valid) m_retired++;
      m_valid = flush_W ? 1'b0 : valid_M;
      m_rw    = flush_W ? 1'b0 : REGWRITE_M;
      m_mtr = MEMTOREG_M; m_op = memop_M; m_addr = aluout_M; m_data = readdata_M;
      m_wr  = writereg_M; m_wrote = 0;
    end else begin
      m_wrote = 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      bit mis, rw;
      mis = m_valid && m_mtr && ref_misalign(m_op, m_addr);
      rw  = m_valid && m_rw && !mis && (m_wr != 0) && !m_wrote;
      chk("model_regwrite", {31'b0, REGWRITE_WB}, {31'b0, rw});
      chk("model_misalign", {31'b0, misalign_WB}, {31'b0, mis});
      if (m_valid) begin
        chk("model_result", result_WB, m_mtr ? ref_load(m_op, m_addr, m_data) : m_addr);
        chk("model_writereg", {27'b0, writereg_WB}, {27'b0, m_wr});
      end
`ifdef WB_RETIRE_CNT_EN
      chk("model_retired", {{(32-CntW){1'b0}}, retired_WB}, m_retired % (1 << CntW));
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic mtr, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] d, input logic [4:0] wr);
    valid_M = v; REGWRITE_M = rw; MEMTOREG_M = mtr; memop_M = op;
    aluout_M = a; readdata_M = d; writereg_M = wr;
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_regwrite"}, {31'b0, REGWRITE_WB}, 32'd0);
    chk({name, "_result"}, result_WB, 32'd0);
    chk({name, "_writereg"}, {27'b0, writereg_WB}, 32'd0);
    chk({name, "_misalign"}, {31'b0, misalign_WB}, 32'd0);
`ifdef WB_RETIRE_CNT_EN
    chk({name, "_retired"}, {{(32-CntW){1'b0}}, retired_WB}, 32'd0);
`endif
  endtask

  localparam logic [31:0] Rd = 32'h8070_6050;

  initial begin
    reset = 1'b0; stall_W = 1'b0; flush_W = 1'b0;
    drive(1, 1, 1, 3'd0, 32'h10, 32'hFFFF_FFFF, 5'd3);
    tick(); tick();
    chk_zero("reset_state");
    cmp_en = 1'b1;
    reset = 1'b1;

    // LB, offset 3 -> sign-extended 0x80
    drive(1, 1, 1, 3'd3, 32'h103, Rd, 5'd8); tick();
    chk("lb_regwrite", {31'b0, REGWRITE_WB}, 32'd1);
    chk("lb_writereg", {27'b0, writereg_WB}, 32'd8);
    chk("lb_result", result_WB, 32'hFFFF_FF80);
    // LHU offset 2
    drive(1, 1, 1, 3'd2, 32'h102, Rd, 5'd9); tick();
    chk("lhu_result", result_WB, 32'h0000_8070);
    // LH offset 1 -> misaligned, write suppressed
    drive(1, 1, 1, 3'd1, 32'h101, Rd, 5'd10); tick();
    chk("lh_mis_misalign", {31'b0, misalign_WB}, 32'd1);
    chk("lh_mis_regwrite", {31'b0, REGWRITE_WB}, 32'd0);
    // ALU result to $0
    drive(1, 1, 0, 3'd0, 32'h1234, Rd, 5'd0); tick();
    chk("x0_regwrite", {31'b0, REGWRITE_WB}, 32'd0);
    chk("x0_result", result_WB, 32'h1234);
    // Further load patterns
    drive(1, 1, 1, 3'd4, 32'h100, Rd, 5'd11); tick();
    chk("lbu0_result", result_WB, 32'h0000_0050);
    drive(1, 1, 1, 3'd3, 32'h101, Rd, 5'd11); tick();
    chk("lb1_result", result_WB, 32'h0000_0060);
    drive(1, 1, 1, 3'd1, 32'h102, Rd, 5'd12); tick();
    chk("lh2_result", result_WB, 32'hFFFF_8070);
    drive(1, 1, 1, 3'd0, 32'h100, Rd, 5'd13); tick();
    chk("lw_result", result_WB, Rd);
    drive(1, 1, 1, 3'd0, 32'h102, Rd, 5'd13); tick();
    chk("lw_mis_misalign", {31'b0, misalign_WB}, 32'd1);
    drive(1, 1, 1, 3'd6, 32'h104, Rd, 5'd14); tick();
    chk("op6_result", result_WB, Rd);
    drive(1, 1, 1, 3'd7, 32'h105, Rd, 5'd14); tick();
    chk("op7_misalign", {31'b0, misalign_WB}, 32'd1);
    drive(1, 1, 1, 3'd4, 32'h107, Rd, 5'd15); tick();
    chk("lbu3_result", result_WB, 32'h0000_0080);
    drive(0, 1, 0, 3'd0, 32'h77, Rd, 5'd15); tick();
    chk("invalid_regwrite", {31'b0, REGWRITE_WB}, 32'd0);

    // Stall for three cycles: only the first cycle writes
    drive(1, 1, 0, 3'd0, 32'h55, Rd, 5'd5); tick();
    chk("stall0_regwrite", {31'b0, REGWRITE_WB}, 32'd1);
    stall_W = 1'b1;
    drive(1, 1, 0, 3'd0, 32'h66, Rd, 5'd6);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold_regwrite", {31'b0, REGWRITE_WB}, 32'd0);
      chk("stall_hold_writereg", {27'b0, writereg_WB}, 32'd5);
    end
    stall_W = 1'b0; tick();
    chk("stall_release_writereg", {27'b0, writereg_WB}, 32'd6);
    chk("stall_release_regwrite", {31'b0, REGWRITE_WB}, 32'd1);

    // Flush together with stall -> bubble
    drive(1, 1, 0, 3'd0, 32'h88, Rd, 5'd7); tick();
    stall_W = 1'b1; flush_W = 1'b1; tick();
    chk("flush_stall_regwrite", {31'b0, REGWRITE_WB}, 32'd0);
    stall_W = 1'b0; flush_W = 1'b0;
    drive(1, 1, 0, 3'd0, 32'h99, Rd, 5'd17); tick();
    flush_W = 1'b1; tick();
    chk("flush_regwrite", {31'b0, REGWRITE_WB}, 32'd0);
    flush_W = 1'b0;

    // Asynchronous reset with a live load in WB
    drive(1, 1, 1, 3'd3, 32'h103, Rd, 5'd8); tick();
    chk("pre_reset_regwrite", {31'b0, REGWRITE_WB}, 32'd1);
    #2 reset = 1'b0;
    #1 chk_zero("async_reset");
    tick(); reset = 1'b1;

    // Reset during a stall discards the held instruction
    drive(1, 1, 1, 3'd0, 32'h200, 32'hDEAD_BEEF, 5'd12); tick();
    stall_W = 1'b1; tick();
    #2 reset = 1'b0;
    #1 chk_zero("stall_reset");
    tick(); stall_W = 1'b0; reset = 1'b1;
    drive(0, 0, 0, 3'd0, 32'h0, 32'h0, 5'd0); tick();
    chk("after_stall_reset_regwrite", {31'b0, REGWRITE_WB}, 32'd0);

`ifdef WB_RETIRE_CNT_EN
    // Counter wrap: 16 retirements on a 4-bit counter return to zero
    reset = 1'b0; tick(); reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, 0, 3'd0, 32'h300 + i, Rd, 5'd1); tick();
    end
    chk("wrap_pre", {{(32-CntW){1'b0}}, retired_WB}, 32'd15);
    drive(0, 0, 0, 3'd0, 32'h0, 32'h0, 5'd0); tick();
    chk("wrap_zero", {{(32-CntW){1'b0}}, retired_WB}, 32'd0);
`endif

    tick(); tick();
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
